// File: rtl/mc_controller_ws.sv
// Multicycle MIPS control unit with merged ALU-control decode, memory wait states,
// configurable instruction-fetch beat count and a sticky bus-timeout error state.
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH   | read one instruction beat per memready, advance PC per beat
// DECODE  | compute branch target, dispatch on op
// MEMADR  | address / immediate-op ALU step
// LBRD    | byte load read, waits for memready
// LBWR    | write loaded byte to register file
// SBWR    | byte store, held until memready
// IMMWR   | write immediate-op result to rt
// RTYPEEX | R-type ALU step
// RTYPEWR | write R-type result to rd
// BEQEX   | branch if equal
// BNEEX   | branch if not equal
// JEX     | jump
// ERROR   | bus timeout, all controls idle until reset

module mc_controller_ws #(
    parameter int FETCHBEATS = 4,
    parameter int WAITMAX    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  memready,
    output logic                  memread,
    output logic                  memwrite,
    output logic                  alusrca,
    output logic                  memtoreg,
    output logic                  iord,
    output logic                  regwrite,
    output logic                  regdst,
    output logic                  immzero,
    output logic                  pcen,
    output logic [1:0]            pcsource,
    output logic [1:0]            alusrcb,
    output logic [FETCHBEATS-1:0] irwrite,
    output logic [2:0]            alucont,
    output logic                  illegal,
    output logic                  error
);

    localparam int              BW       = (FETCHBEATS > 1) ? $clog2(FETCHBEATS) : 1;
    localparam logic [BW-1:0]   LASTBEAT = BW'(FETCHBEATS - 1);
    localparam logic [7:0]      WAITLAST = 8'(WAITMAX - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, IMMWR,
        RTYPEEX, RTYPEWR, BEQEX, BNEEX, JEX, ERROR
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic [7:0]      waitcnt;
    logic            waiting;
    logic            timeout;

    assign waiting = (state == FETCH) || (state == LBRD) || (state == SBWR);
    // memready in the terminal-count cycle still completes the access
    assign timeout = waiting && !memready && (waitcnt == WAITLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            beat    <= '0;
            waitcnt <= '0;
        end else begin
            if (waiting && !memready && !timeout)
                waitcnt <= waitcnt + 8'd1;
            else
                waitcnt <= '0;

            case (state)
                FETCH: begin
                    if (timeout) begin
                        state <= ERROR;
                    end else if (memready) begin
                        if (beat == LASTBEAT) begin
                            beat  <= '0;
                            state <= DECODE;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                DECODE: begin
                    case (op)
                        OP_LB, OP_SB, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state <= MEMADR;
                        OP_RTYPE: state <= RTYPEEX;
                        OP_BEQ:   state <= BEQEX;
                        OP_BNE:   state <= BNEEX;
                        OP_J:     state <= JEX;
                        default:  state <= FETCH;
                    endcase
                end
                MEMADR: begin
                    case (op)
                        OP_LB:                              state <= LBRD;
                        OP_SB:                              state <= SBWR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:  state <= IMMWR;
                        default:                            state <= FETCH;
                    endcase
                end
                LBRD: begin
                    if (timeout)       state <= ERROR;
                    else if (memready) state <= LBWR;
                end
                SBWR: begin
                    if (timeout)       state <= ERROR;
                    else if (memready) state <= FETCH;
                end
                RTYPEEX: state <= RTYPEWR;
                ERROR:   state <= ERROR;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        alusrca  = 1'b0;
        memtoreg = 1'b0;
        iord     = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        immzero  = 1'b0;
        pcen     = 1'b0;
        pcsource = 2'b00;
        alusrcb  = 2'b00;
        irwrite  = '0;
        alucont  = 3'b010;
        illegal  = 1'b0;
        error    = 1'b0;

        case (state)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcen    = memready;
                irwrite = memready ? (FETCHBEATS'(1) << beat) : '0;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                    OP_RTYPE, OP_BEQ, OP_BNE, OP_J: illegal = 1'b0;
                    default:                        illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin immzero = 1'b1; alucont = 3'b000; end
                    OP_ORI:  begin immzero = 1'b1; alucont = 3'b001; end
                    OP_XORI: begin immzero = 1'b1; alucont = 3'b011; end
                    default: alucont = 3'b010;
                endcase
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            IMMWR: regwrite = 1'b1;
            RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: alucont = 3'b010;
                    6'b100010: alucont = 3'b110;
                    6'b100100: alucont = 3'b000;
                    6'b100101: alucont = 3'b001;
                    6'b100110: alucont = 3'b011;
                    6'b101010: alucont = 3'b111;
                    default:   alucont = 3'b101;
                endcase
            end
            RTYPEWR: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca  = 1'b1;
                alucont  = 3'b110;
                pcsource = 2'b01;
                pcen     = (state == BEQEX) ? zero : ~zero;
            end
            JEX: begin
                pcen     = 1'b1;
                pcsource = 2'b10;
            end
            ERROR: begin
                alucont = 3'b000;
                error   = 1'b1;
            end
            default: alucont = 3'b010;
        endcase

        if (reset) begin
            memread  = 1'b0;
            memwrite = 1'b0;
            alusrca  = 1'b0;
            memtoreg = 1'b0;
            iord     = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            immzero  = 1'b0;
            pcen     = 1'b0;
            pcsource = 2'b00;
            alusrcb  = 2'b00;
            irwrite  = '0;
            alucont  = 3'b000;
            illegal  = 1'b0;
            error    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Cycle-by-cycle table bench for mc_controller_ws (FETCHBEATS=4, WAITMAX=4),
// plus hand-written sequences for the pcen count and reset during a wait.
module tb_mc_controller_ws;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       memready = 1'b1;
    logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, immzero, pcen;
    logic [1:0] pcsource, alusrcb;
    logic [3:0] irwrite;
    logic [2:0] alucont;
    logic       illegal, error;

    int checks = 0;
    int errors = 0;

    mc_controller_ws #(.FETCHBEATS(4), .WAITMAX(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .memtoreg(memtoreg),
        .iord(iord), .regwrite(regwrite), .regdst(regdst), .immzero(immzero), .pcen(pcen),
        .pcsource(pcsource), .alusrcb(alusrcb), .irwrite(irwrite), .alucont(alucont),
        .illegal(illegal), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, immzero, pcen;
        logic [1:0] pcsource, alusrcb;
        logic [3:0] irwrite;
        logic [2:0] alucont;
        logic       illegal, error;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        ctl_t       exp;
        string      tag;
    } vec_t;

    ctl_t act;
    assign act = {memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, immzero, pcen,
                  pcsource, alusrcb, irwrite, alucont, illegal, error};

    vec_t vecs[$];
    ctl_t sb[$];

    localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, ADDI = 6'b001000, ANDI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010, BAD = 6'b111111;

    function automatic ctl_t base();
        ctl_t c = '0;
        c.alucont = 3'b010;
        return c;
    endfunction
    function automatic ctl_t e_fetch(int b, logic rdy);
        ctl_t c = base();
        c.memread = 1'b1; c.alusrcb = 2'b01; c.pcen = rdy;
        c.irwrite = rdy ? (4'b0001 << b) : 4'b0000;
        return c;
    endfunction
    function automatic ctl_t e_dec(logic ill);
        ctl_t c = base();
        c.alusrcb = 2'b11; c.illegal = ill;
        return c;
    endfunction
    function automatic ctl_t e_mem(logic imz, logic [2:0] alu);
        ctl_t c = base();
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.immzero = imz; c.alucont = alu;
        return c;
    endfunction
    function automatic ctl_t e_lbrd();
        ctl_t c = base(); c.memread = 1'b1; c.iord = 1'b1; return c;
    endfunction
    function automatic ctl_t e_lbwr();
        ctl_t c = base(); c.regwrite = 1'b1; c.memtoreg = 1'b1; return c;
    endfunction
    function automatic ctl_t e_sbwr();
        ctl_t c = base(); c.memwrite = 1'b1; c.iord = 1'b1; return c;
    endfunction
    function automatic ctl_t e_immwr();
        ctl_t c = base(); c.regwrite = 1'b1; return c;
    endfunction
    function automatic ctl_t e_rex(logic [2:0] alu);
        ctl_t c = base(); c.alusrca = 1'b1; c.alucont = alu; return c;
    endfunction
    function automatic ctl_t e_rwr();
        ctl_t c = base(); c.regdst = 1'b1; c.regwrite = 1'b1; return c;
    endfunction
    function automatic ctl_t e_br(logic take);
        ctl_t c = base();
        c.alusrca = 1'b1; c.alucont = 3'b110; c.pcsource = 2'b01; c.pcen = take;
        return c;
    endfunction
    function automatic ctl_t e_j();
        ctl_t c = base(); c.pcen = 1'b1; c.pcsource = 2'b10; return c;
    endfunction
    function automatic ctl_t e_err();
        ctl_t c = '0; c.error = 1'b1; return c;
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy, input ctl_t e, input string tag);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy; v.exp = e; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic [5:0] o, input logic [5:0] f);
        for (int b = 0; b < 4; b++) add(1'b0, o, f, 1'b0, 1'b1, e_fetch(b, 1'b1), "fetch");
    endtask

    task automatic check(input ctl_t got, input ctl_t exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int   npcen;
        bit   seen;

        // reset
        add(1'b1, ADDI, 6'd0, 1'b0, 1'b1, ctl_t'('0), "reset");
        // ADDI
        add_fetch(ADDI, 6'd0);
        add(1'b0, ADDI, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "addi_dec");
        add(1'b0, ADDI, 6'd0, 1'b0, 1'b1, e_mem(1'b0, 3'b010), "addi_mem");
        add(1'b0, ADDI, 6'd0, 1'b0, 1'b1, e_immwr(), "addi_wr");
        // ORI with 3 wait cycles on beat 2; the ready cycle hits the terminal count
        add(1'b0, ORI, 6'd0, 1'b0, 1'b1, e_fetch(0, 1'b1), "fetch");
        add(1'b0, ORI, 6'd0, 1'b0, 1'b1, e_fetch(1, 1'b1), "fetch");
        for (int k = 0; k < 3; k++) add(1'b0, ORI, 6'd0, 1'b0, 1'b0, e_fetch(2, 1'b0), "fetch_wait");
        add(1'b0, ORI, 6'd0, 1'b0, 1'b1, e_fetch(2, 1'b1), "fetch_ready");
        add(1'b0, ORI, 6'd0, 1'b0, 1'b1, e_fetch(3, 1'b1), "fetch");
        add(1'b0, ORI, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "ori_dec");
        add(1'b0, ORI, 6'd0, 1'b0, 1'b1, e_mem(1'b1, 3'b001), "ori_mem");
        add(1'b0, ORI, 6'd0, 1'b0, 1'b1, e_immwr(), "ori_wr");
        // XORI, ANDI
        add_fetch(XORI, 6'd0);
        add(1'b0, XORI, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "xori_dec");
        add(1'b0, XORI, 6'd0, 1'b0, 1'b1, e_mem(1'b1, 3'b011), "xori_mem");
        add(1'b0, XORI, 6'd0, 1'b0, 1'b1, e_immwr(), "xori_wr");
        add_fetch(ANDI, 6'd0);
        add(1'b0, ANDI, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "andi_dec");
        add(1'b0, ANDI, 6'd0, 1'b0, 1'b1, e_mem(1'b1, 3'b000), "andi_mem");
        add(1'b0, ANDI, 6'd0, 1'b0, 1'b1, e_immwr(), "andi_wr");
        // branches
        add_fetch(BNE, 6'd0);
        add(1'b0, BNE, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "bne_dec");
        add(1'b0, BNE, 6'd0, 1'b0, 1'b1, e_br(1'b1), "bne_z0");
        add_fetch(BNE, 6'd0);
        add(1'b0, BNE, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "bne_dec");
        add(1'b0, BNE, 6'd0, 1'b1, 1'b1, e_br(1'b0), "bne_z1");
        add_fetch(BEQ, 6'd0);
        add(1'b0, BEQ, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "beq_dec");
        add(1'b0, BEQ, 6'd0, 1'b1, 1'b1, e_br(1'b1), "beq_z1");
        add_fetch(BEQ, 6'd0);
        add(1'b0, BEQ, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "beq_dec");
        add(1'b0, BEQ, 6'd0, 1'b0, 1'b1, e_br(1'b0), "beq_z0");
        add_fetch(JMP, 6'd0);
        add(1'b0, JMP, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "j_dec");
        add(1'b0, JMP, 6'd0, 1'b0, 1'b1, e_j(), "j_ex");
        // illegal op, then R-type
        add_fetch(BAD, 6'd0);
        add(1'b0, BAD, 6'd0, 1'b0, 1'b1, e_dec(1'b1), "illegal_dec");
        add_fetch(RT, 6'b100110);
        add(1'b0, RT, 6'b100110, 1'b0, 1'b1, e_dec(1'b0), "rt_dec");
        add(1'b0, RT, 6'b100110, 1'b0, 1'b1, e_rex(3'b011), "rt_xor");
        add(1'b0, RT, 6'b100110, 1'b0, 1'b1, e_rwr(), "rt_wr");
        add_fetch(RT, 6'b111111);
        add(1'b0, RT, 6'b111111, 1'b0, 1'b1, e_dec(1'b0), "rt_dec");
        add(1'b0, RT, 6'b111111, 1'b0, 1'b1, e_rex(3'b101), "rt_unknown");
        add(1'b0, RT, 6'b111111, 1'b0, 1'b1, e_rwr(), "rt_wr");
        // LB with two wait cycles
        add_fetch(LB, 6'd0);
        add(1'b0, LB, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "lb_dec");
        add(1'b0, LB, 6'd0, 1'b0, 1'b1, e_mem(1'b0, 3'b010), "lb_mem");
        add(1'b0, LB, 6'd0, 1'b0, 1'b0, e_lbrd(), "lb_rd_wait");
        add(1'b0, LB, 6'd0, 1'b0, 1'b0, e_lbrd(), "lb_rd_wait");
        add(1'b0, LB, 6'd0, 1'b0, 1'b1, e_lbrd(), "lb_rd");
        add(1'b0, LB, 6'd0, 1'b0, 1'b1, e_lbwr(), "lb_wr");
        // SB: ready exactly at the terminal count completes normally
        add_fetch(SB, 6'd0);
        add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "sb_dec");
        add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_mem(1'b0, 3'b010), "sb_mem");
        for (int k = 0; k < 3; k++) add(1'b0, SB, 6'd0, 1'b0, 1'b0, e_sbwr(), "sb_wait");
        add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_sbwr(), "sb_ready_at_limit");
        // SB timeout: 4 low cycles -> ERROR, sticky until reset
        add_fetch(SB, 6'd0);
        add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_dec(1'b0), "sb_dec");
        add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_mem(1'b0, 3'b010), "sb_mem");
        for (int k = 0; k < 4; k++) add(1'b0, SB, 6'd0, 1'b0, 1'b0, e_sbwr(), "sb_wait");
        for (int k = 0; k < 3; k++) add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_err(), "error_sticky");
        add(1'b1, SB, 6'd0, 1'b0, 1'b1, ctl_t'('0), "reset_in_error");
        add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_fetch(0, 1'b1), "fetch_after_reset");
        add(1'b0, SB, 6'd0, 1'b0, 1'b1, e_fetch(1, 1'b1), "fetch");

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; memready = vecs[i].rdy;
            sb.push_back(vecs[i].exp);
            @(negedge clk);
            check(act, sb.pop_front(), $sformatf("%s[%0d]", vecs[i].tag, i));
        end

        // ADDI from reset: count pcen pulses until the register write, bounded
        @(posedge clk); #1;
        reset = 1'b1; op = ADDI; memready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        npcen = 0;
        seen  = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pcen) npcen++;
            if (regwrite) seen = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL addi_regwrite_seen: got 0 expected 1 within 20 cycles");
        end
        checks++;
        if (npcen != 4) begin
            errors++;
            $display("FAIL addi_pcen_count: got %0d expected 4", npcen);
        end

        // reset asserted during a fetch wait aborts it and restarts at beat 0
        memready = 1'b1;
        @(negedge clk);
        check(act, e_fetch(0, 1'b1), "fetch_b0");
        @(posedge clk); #1;
        memready = 1'b0;
        @(negedge clk);
        check(act, e_fetch(1, 1'b0), "fetch_b1_wait");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check(act, ctl_t'('0), "reset_mid_fetch");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check(act, e_fetch(0, 1'b0), "restart_wait");
        @(posedge clk); #1;
        memready = 1'b1;
        @(negedge clk);
        check(act, e_fetch(0, 1'b1), "restart_beat0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
